instruction_fetch_stage: RTL and testbench

//  Upstream fetch stage of the pipelined CPU. Owns the program counter and drives the

---
 rtl/instruction_fetch_stage_pkg.sv | 27 ++
 rtl/instruction_fetch_stage_if_id_register.sv | 37 +++
 rtl/instruction_fetch_stage.sv | 105 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants, fetch FSM state codes and small helpers for the instruction fetch stage.
package instruction_fetch_stage_pkg;

  localparam int          IF_ADDR_W   = 16;
  localparam int          IF_INSN_W   = 28;
  localparam int          IF_COUNT_W  = 16;
  localparam logic [15:0] IF_RESET_PC = 16'd0;
  localparam logic [27:0] IF_NOP_WORD = 28'd0;

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_REFILL = 2'b01,
    S_IDLE   = 2'b10
  } fetch_state_e;

  // Saturating increment: the fetch counter sticks at all-ones instead of wrapping.
  function automatic logic [IF_COUNT_W-1:0] sat_inc(input logic [IF_COUNT_W-1:0] val);
    logic [IF_COUNT_W-1:0] res;
    if (val == {IF_COUNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(IF_COUNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// Generic enable / synchronous-clear D register used as the IF/ID pipeline register.
module if_id_register #(
  parameter int               WIDTH       = 45,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] reg_d;
  logic [WIDTH-1:0] reg_q;

  // Load on enable, otherwise hold.
  always_comb begin
    reg_d = reg_q;
    if (en) begin
      reg_d = d;
    end else begin
      reg_d = reg_q;
    end
  end

  // Storage with synchronous clear taking priority over load.
  always_ff @(posedge clk) begin
    if (clr) begin
      reg_q <= CLEAR_VALUE;
    end else begin
      reg_q <= reg_d;
    end
  end

  assign q = reg_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives the ROM address, loads IF/ID and counts valid fetches.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                INSN_W   = IF_INSN_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC,
  parameter logic [INSN_W-1:0] NOP_WORD = IF_NOP_WORD
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iStall,
  input  logic                  iBranchTaken,
  input  logic [ADDR_W-1:0]     iBranchTarget,
  output logic [ADDR_W-1:0]     oInstructionAddress,
  input  logic [INSN_W-1:0]     iInstruction,
  output logic [INSN_W-1:0]     oInstruction,
  output logic [ADDR_W-1:0]     oPC,
  output logic                  oValid,
  output logic [IF_COUNT_W-1:0] oFetchCount
);

  localparam int IFID_W = INSN_W + ADDR_W + 1;
  localparam logic [IFID_W-1:0] IFID_CLEAR = {NOP_WORD, {ADDR_W{1'b0}}, 1'b0};

  fetch_state_e          state_d, state_q;
  logic [ADDR_W-1:0]     pc_d, pc_q;
  logic [IF_COUNT_W-1:0] count_d, count_q;
  logic                  flush_s;
  logic                  ifid_clr_s;
  logic                  ifid_en_s;
  logic [IFID_W-1:0]     ifid_d_s;
  logic [IFID_W-1:0]     ifid_q_s;

  // Next PC, FSM and counter; redirect beats stall, which beats advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    count_d   = count_q;
    flush_s   = 1'b0;
    ifid_en_s = 1'b0;
    ifid_d_s  = {iInstruction, pc_q, 1'b1};
    case (state_q)
      S_RUN, S_REFILL: begin
        if (iBranchTaken) begin
          pc_d    = iBranchTarget;
          flush_s = 1'b1;
          state_d = S_REFILL;
        end else if (iStall) begin
          state_d = state_q;
        end else begin
          pc_d      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          count_d   = sat_inc(count_q);
          ifid_en_s = 1'b1;
          state_d   = S_RUN;
        end
      end
      default: begin
        // Unreachable encodings recover to RUN with a bubble in IF/ID.
        state_d = S_RUN;
        flush_s = 1'b1;
      end
    endcase
  end

  // IF/ID is cleared by reset as well as by a flush.
  always_comb begin
    if (Reset) begin
      ifid_clr_s = 1'b1;
    end else begin
      ifid_clr_s = flush_s;
    end
  end

  // PC, FSM state and fetch counter registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      count_q <= {IF_COUNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_register #(
    .WIDTH       (IFID_W),
    .CLEAR_VALUE (IFID_CLEAR)
  ) u_if_id (
    .clk (Clock),
    .clr (ifid_clr_s),
    .en  (ifid_en_s),
    .d   (ifid_d_s),
    .q   (ifid_q_s)
  );

  assign oInstructionAddress = pc_q;
  assign oInstruction        = ifid_q_s[IFID_W-1 -: INSN_W];
  assign oPC                 = ifid_q_s[ADDR_W:1];
  assign oValid              = ifid_q_s[0];
  assign oFetchCount         = count_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized and directed bench for instruction_fetch_stage against a behavioural fetch model.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [15:0] tgt = 16'd0;
  logic [15:0] addr;
  logic [27:0] rom_data;
  logic [27:0] insn;
  logic [15:0] opc;
  logic        valid;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model of the architectural fetch state.
  logic [15:0] m_pc;
  logic [27:0] m_insn;
  logic [15:0] m_opc;
  logic        m_valid;
  logic [15:0] m_cnt;

  instruction_fetch_stage dut (
    .Clock               (clk),
    .Reset               (rst),
    .iStall              (stall),
    .iBranchTaken        (br),
    .iBranchTarget       (tgt),
    .oInstructionAddress (addr),
    .iInstruction        (rom_data),
    .oInstruction        (insn),
    .oPC                 (opc),
    .oValid              (valid),
    .oFetchCount         (cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] rom(input logic [15:0] a);
    logic [15:0] lo;
    lo = a ^ 16'h5A3C;
    return {a[11:0] + 12'h3C1, lo};
  endfunction

  assign rom_data = rom(addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge from the spec's priority rules.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = 16'd0; m_insn = 28'd0; m_opc = 16'd0; m_valid = 1'b0; m_cnt = 16'd0;
    end else if (br) begin
      m_pc = tgt; m_insn = 28'd0; m_opc = 16'd0; m_valid = 1'b0;
    end else if (!stall) begin
      m_insn  = rom(m_pc);
      m_opc   = m_pc;
      m_valid = 1'b1;
      m_pc    = 16'((32'(m_pc) + 1) % 65536);
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("addr",  32'(addr),  32'(m_pc));
      chk("insn",  32'(insn),  32'(m_insn));
      chk("opc",   32'(opc),   32'(m_opc));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("count", 32'(cnt),   32'(m_cnt));
    end
  end

  task automatic tick(input logic r, input logic s, input logic b, input logic [15:0] t);
    rst = r; stall = s; br = b; tgt = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_to(input int n);
    tick(1'b1, 1'b0, 1'b0, 16'd0);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 16'd0);
  endtask

  initial begin
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, 16'd0);
    chk_en = 1'b1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_count", 32'(cnt), 32'd0);

    // Six free-running fetches from reset.
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b0, 1'b0, 16'd0);
      chk("seq_opc", 32'(opc), 32'(i));
      chk("seq_valid", 32'(valid), 32'd1);
    end
    chk("seq_count", 32'(cnt), 32'd6);
    chk("seq_insn", 32'(insn), 32'(rom(16'd5)));

    // Stall three cycles with PC at 4.
    go_to(4);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, 16'd0);
      chk("stall_addr", 32'(addr), 32'd4);
      chk("stall_opc", 32'(opc), 32'd3);
      chk("stall_count", 32'(cnt), 32'd4);
    end
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("unstall_opc4", 32'(opc), 32'd4);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("unstall_opc5", 32'(opc), 32'd5);

    // Redirect to 5 from PC 10.
    go_to(10);
    tick(1'b0, 1'b0, 1'b1, 16'd5);
    chk("br_valid", 32'(valid), 32'd0);
    chk("br_insn", 32'(insn), 32'd0);
    chk("br_addr", 32'(addr), 32'd5);
    chk("br_count", 32'(cnt), 32'd10);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("refill_opc", 32'(opc), 32'd5);
    chk("refill_valid", 32'(valid), 32'd1);

    // Redirect and stall together at PC 7.
    go_to(7);
    tick(1'b0, 1'b1, 1'b1, 16'd2);
    chk("brst_addr", 32'(addr), 32'd2);
    chk("brst_valid", 32'(valid), 32'd0);
    // Stall inside refill holds the bubble.
    tick(1'b0, 1'b1, 1'b0, 16'd0);
    chk("refst_valid", 32'(valid), 32'd0);
    chk("refst_addr", 32'(addr), 32'd2);

    // PC wrap and counter saturation.
    tick(1'b0, 1'b0, 1'b1, 16'hFFFF);
    #2;
    force dut.count_q = 16'hFFFD;
    m_cnt = 16'hFFFD;
    #1;
    release dut.count_q;
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("wrap_opc_ffff", 32'(opc), 32'hFFFF);
    chk("wrap_addr0", 32'(addr), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("wrap_opc_0", 32'(opc), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("sat_count", 32'(cnt), 32'hFFFF);

    // Reset during refill with stall asserted.
    tick(1'b0, 1'b0, 1'b1, 16'd40);
    tick(1'b1, 1'b1, 1'b0, 16'd0);
    chk("rstref_addr", 32'(addr), 32'd0);
    chk("rstref_valid", 32'(valid), 32'd0);
    chk("rstref_insn", 32'(insn), 32'd0);
    chk("rstref_opc", 32'(opc), 32'd0);
    chk("rstref_count", 32'(cnt), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 16'd0);
    chk("post_rst_opc", 32'(opc), 32'd0);
    chk("post_rst_valid", 32'(valid), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
           16'($urandom));
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
